// File: rtl/spi_master_ctrl_if.sv
// +----------------------------------------------------------------------------+
// | Module      : spi_master_ctrl_if                                           |
// | Description : Bus-side strobes and data words between the Wishbone slave   |
// |               front end and the SPI master sequencer.                      |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

interface spi_master_ctrl_if;
  logic [10:0] dout;
  logic        cmd;
  logic        wr;
  logic        rd;
  logic [9:0]  din;
  logic        ack;

  modport master (output dout, cmd, wr, rd, input  din, ack);
  modport slave  (input  dout, cmd, wr, rd, output din, ack);
endinterface

`default_nettype wire

// File: rtl/spi_master_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : spi_master_ctrl                                              |
// | Description : Configuration register plus 8-bit full-duplex SPI master     |
// |               (modes 0-3) driven by level strobes from the bus front end.  |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module spi_master_ctrl #(
  parameter logic [7:0] DIV_RESET  = 8'd3,
  parameter logic       CPOL_RESET = 1'b0,
  parameter logic       CPHA_RESET = 1'b0
) (
  input  wire logic           clk,
  input  wire logic           rst,
  spi_master_ctrl_if.slave    bus,
  output logic                spi_sclk,
  output logic                spi_mosi,
  input  wire logic           spi_miso,
  output logic                spi_ss_n
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_setup = 2'd1;
  localparam logic [1:0] c_st_shift = 2'd2;
  localparam logic [1:0] c_st_hold  = 2'd3;

  logic [1:0] state_q,    state_d;
  logic       req_q,      req_d;
  logic       ack_q,      ack_d;
  logic [7:0] div_q,      div_d;
  logic       cpol_q,     cpol_d;
  logic       cpha_q,     cpha_d;
  logic       ss_en_q,    ss_en_d;
  logic [7:0] cnt_q,      cnt_d;
  logic [4:0] edge_cnt_q, edge_cnt_d;
  logic [7:0] tx_sr_q,    tx_sr_d;
  logic [7:0] rx_sr_q,    rx_sr_d;
  logic [7:0] rx_data_q,  rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       sclk_q,     sclk_d;
  logic       mosi_q,     mosi_d;
  logic       ss_n_q,     ss_n_d;
  logic       miso_q,     miso_d;
  logic       smp_pend_q, smp_pend_d;

  logic w_req;
  logic w_accept;
  logic w_busy;
  logic w_tick;
  logic w_lead;
  logic w_sample;
  logic w_done;

  always_comb begin
    w_req      = bus.cmd | bus.wr | bus.rd;
    w_accept   = w_req & ~req_q;
    w_busy     = (state_q != c_st_idle);
    w_tick     = (cnt_q == 8'd0);
    w_lead     = ~edge_cnt_q[0];
    w_sample   = w_lead ^ cpha_q;
    w_done     = 1'b0;

    state_d    = state_q;
    req_d      = w_req;
    ack_d      = w_accept;
    div_d      = div_q;
    cpol_d     = cpol_q;
    cpha_d     = cpha_q;
    ss_en_d    = ss_en_q;
    cnt_d      = cnt_q;
    edge_cnt_d = edge_cnt_q;
    tx_sr_d    = tx_sr_q;
    rx_sr_d    = rx_sr_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    ss_n_d     = ss_n_q;
    miso_d     = spi_miso;
    smp_pend_d = 1'b0;

    // Sampling is deferred one clock so the registered miso reflects the line at the edge.
    if (smp_pend_q) begin
      rx_sr_d = {rx_sr_q[6:0], miso_q};
    end

    if (w_busy) begin
      cnt_d = w_tick ? div_q : cnt_q - 8'd1;
    end

    case (state_q)
      c_st_idle: begin
        sclk_d = cpol_q;
      end
      c_st_setup, c_st_shift: begin
        if (w_tick) begin
          if (edge_cnt_q == 5'd16) begin
            state_d = c_st_hold;
          end else begin
            state_d    = c_st_shift;
            sclk_d     = ~sclk_q;
            edge_cnt_d = edge_cnt_q + 5'd1;
            if (w_sample) begin
              smp_pend_d = 1'b1;
            end else if (cpha_q || (edge_cnt_q != 5'd15)) begin
              mosi_d  = tx_sr_q[7];
              tx_sr_d = {tx_sr_q[6:0], 1'b0};
            end
          end
        end
      end
      c_st_hold: begin
        if (w_tick) begin
          state_d    = c_st_idle;
          ss_n_d     = 1'b1;
          rx_data_d  = rx_sr_q;
          rx_valid_d = 1'b1;
          w_done     = 1'b1;
        end
      end
      default: begin
        state_d = c_st_idle;
      end
    endcase

    if (w_accept) begin
      if (bus.cmd) begin
        if (!w_busy) begin
          div_d   = bus.dout[7:0];
          cpol_d  = bus.dout[8];
          cpha_d  = bus.dout[9];
          ss_en_d = bus.dout[10];
        end
      end else if (bus.wr) begin
        if (!w_busy) begin
          state_d    = c_st_setup;
          cnt_d      = div_q;
          edge_cnt_d = 5'd0;
          ss_n_d     = ~ss_en_q;
          tx_sr_d    = bus.dout[7:0];
          if (!cpha_q) begin
            mosi_d  = bus.dout[7];
            tx_sr_d = {bus.dout[6:0], 1'b0};
          end
        end
      end else if (!w_done) begin
        rx_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= c_st_idle;
      req_q      <= 1'b0;
      ack_q      <= 1'b0;
      div_q      <= DIV_RESET;
      cpol_q     <= CPOL_RESET;
      cpha_q     <= CPHA_RESET;
      ss_en_q    <= 1'b1;
      cnt_q      <= 8'd0;
      edge_cnt_q <= 5'd0;
      tx_sr_q    <= 8'd0;
      rx_sr_q    <= 8'd0;
      rx_data_q  <= 8'd0;
      rx_valid_q <= 1'b0;
      sclk_q     <= CPOL_RESET;
      mosi_q     <= 1'b0;
      ss_n_q     <= 1'b1;
      miso_q     <= 1'b0;
      smp_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      ack_q      <= ack_d;
      div_q      <= div_d;
      cpol_q     <= cpol_d;
      cpha_q     <= cpha_d;
      ss_en_q    <= ss_en_d;
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      tx_sr_q    <= tx_sr_d;
      rx_sr_q    <= rx_sr_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      ss_n_q     <= ss_n_d;
      miso_q     <= miso_d;
      smp_pend_q <= smp_pend_d;
    end
  end

  assign bus.din  = {w_busy, rx_valid_q, rx_data_q};
  assign bus.ack  = ack_q;
  assign spi_sclk = sclk_q;
  assign spi_mosi = mosi_q;
  assign spi_ss_n = ss_n_q;

endmodule

`default_nettype wire

// File: tb/tb_spi_master_ctrl.sv
// +----------------------------------------------------------------------------+
// | Module      : tb_spi_master_ctrl                                           |
// | Description : Randomized self-checking bench for spi_master_ctrl with an   |
// |               SPI slave model and a transfer-level reference model.        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_spi_master_ctrl;

  localparam int K_CMD = 0;
  localparam int K_WR  = 1;
  localparam int K_RD  = 2;

  logic clk;
  logic rst;
  logic spi_sclk;
  logic spi_mosi;
  logic spi_miso;
  logic spi_ss_n;
  logic loop_en;
  logic miso_drv;

  int n_vec;
  int n_err;

  // Reference configuration register, updated only when a cmd lands in idle.
  logic [7:0] m_div;
  logic       m_cpol;
  logic       m_cpha;
  logic       m_ss_en;

  spi_master_ctrl_if bus ();

  spi_master_ctrl #(
    .DIV_RESET  (8'd3),
    .CPOL_RESET (1'b0),
    .CPHA_RESET (1'b0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_ss_n (spi_ss_n)
  );

  assign spi_miso = loop_en ? spi_mosi : miso_drv;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_cmd(input logic [10:0] w);
    m_div   = w[7:0];
    m_cpol  = w[8];
    m_cpha  = w[9];
    m_ss_en = w[10];
  endtask

  task automatic access(input int kind, input logic [10:0] w, input int hold,
                        output int acks, output logic rv_ack);
    acks     = 0;
    rv_ack   = 1'b1;
    bus.dout = w;
    bus.cmd  = (kind == K_CMD);
    bus.wr   = (kind == K_WR);
    bus.rd   = (kind == K_RD);
    for (int i = 0; i < hold + 3; i++) begin
      if (i == hold) begin
        bus.cmd = 1'b0;
        bus.wr  = 1'b0;
        bus.rd  = 1'b0;
      end
      @(posedge clk); #1;
      if (bus.ack === 1'b1) begin
        acks++;
        rv_ack = bus.din[8];
      end
    end
  endtask

  task automatic do_cmd(input logic [10:0] w);
    int   acks;
    logic rv;
    access(K_CMD, w, 2, acks, rv);
    chk("cmd_ack", acks, 1);
    model_cmd(w);
    chk("sclk_idle_cpol", spi_sclk, m_cpol);
  endtask

  // One wr-launched transfer, observed cycle by cycle from the ack cycle onward.
  task automatic xfer(input logic [7:0] tx, input logic [7:0] sb, input logic loop, input logic collide);
    int         h, c, n, last_t, acks, k;
    int         bad_ss, bad_h, bad_mosi;
    logic [7:0] cap;
    logic       prev_sclk, prev_mosi, tog, lead, m_drive;
    h        = int'(m_div) + 1;
    loop_en  = loop;
    k        = 0;
    n        = 0;
    last_t   = 0;
    cap      = 8'd0;
    bad_ss   = 0;
    bad_h    = 0;
    bad_mosi = 0;
    miso_drv = 1'b0;
    if (!m_cpha) begin
      miso_drv = sb[7];
      k        = 1;
    end
    prev_sclk = spi_sclk;
    prev_mosi = spi_mosi;
    bus.dout  = {3'b000, tx};
    bus.wr    = 1'b1;
    @(posedge clk); #1;
    bus.wr = 1'b0;
    c    = 0;
    acks = 0;
    while (bus.din[9] === 1'b1 && c < 2000) begin
      if (bus.ack === 1'b1) acks++;
      if (spi_ss_n !== ~m_ss_en) bad_ss++;
      tog     = (spi_sclk !== prev_sclk);
      lead    = 1'b0;
      m_drive = 1'b0;
      if (tog) begin
        n++;
        if (n == 1) begin
          if (c != h) bad_h++;
        end else if (c - last_t != h) begin
          bad_h++;
        end
        last_t  = c;
        lead    = (n % 2 == 1);
        m_drive = m_cpha ? lead : (!lead && n < 16);
        if (lead == !m_cpha) begin
          cap = {cap[6:0], spi_mosi};
        end else if (k < 8) begin
          miso_drv = sb[7 - k];
          k++;
        end
      end
      if (spi_mosi !== prev_mosi) begin
        if (!(m_drive || (c == 0 && !m_cpha))) bad_mosi++;
      end
      prev_sclk = spi_sclk;
      prev_mosi = spi_mosi;
      if (collide) begin
        if (c == 4 * h) begin
          bus.dout = 11'h022;
          bus.wr   = 1'b1;
        end
        if (c == 4 * h + 1) bus.wr = 1'b0;
        if (c == 4 * h + 3) begin
          bus.dout = 11'h0FF;
          bus.cmd  = 1'b1;
        end
        if (c == 4 * h + 4) bus.cmd = 1'b0;
      end
      @(posedge clk); #1;
      c++;
    end
    chk("xfer_len", c, 18 * h);
    chk("xfer_acks", acks, collide ? 3 : 1);
    chk("sclk_toggles", n, 16);
    chk("half_period", bad_h, 0);
    chk("ss_n_active", bad_ss, 0);
    chk("mosi_edges", bad_mosi, 0);
    chk("mosi_bits", cap, tx);
    chk("din_done", bus.din, {2'b01, sb});
    chk("ss_n_after", spi_ss_n, 1'b1);
    chk("sclk_after", spi_sclk, m_cpol);
    loop_en = 1'b0;
  endtask

  initial begin
    int         acks, c, n;
    logic       rv, prev;
    logic [7:0] tx, sb;
    logic [10:0] w;
    n_vec    = 0;
    n_err    = 0;
    loop_en  = 1'b0;
    miso_drv = 1'b0;
    rst      = 1'b1;
    bus.dout = 11'd0;
    bus.cmd  = 1'b0;
    bus.wr   = 1'b0;
    bus.rd   = 1'b0;
    model_cmd(11'h403);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_din", bus.din, 10'h000);
    chk("rst_ack", bus.ack, 1'b0);
    chk("rst_sclk", spi_sclk, 1'b0);
    chk("rst_mosi", spi_mosi, 1'b0);
    chk("rst_ss_n", spi_ss_n, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Mode 0, div=1, loopback.
    do_cmd(11'h401);
    xfer(8'hA5, 8'hA5, 1'b1, 1'b0);

    // rd held for several cycles: single ack, rx_valid clears on the ack cycle.
    chk("rv_before_rd", bus.din[8], 1'b1);
    access(K_RD, 11'h000, 5, acks, rv);
    chk("rd_acks", acks, 1);
    chk("rd_rv_at_ack", rv, 1'b0);
    chk("rd_busy", bus.din[9], 1'b0);
    chk("rd_data_kept", bus.din[7:0], 8'hA5);

    // Mode 3, div=0, slave returns C3.
    do_cmd(11'h700);
    xfer(8'h3C, 8'hC3, 1'b0, 1'b0);

    // Collisions while busy: wr and cmd acked but ignored.
    do_cmd(11'h401);
    xfer(8'h11, 8'h11, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    chk("no_second_xfer", bus.din[9], 1'b0);
    xfer(8'h5A, 8'h5A, 1'b1, 1'b0);

    // Slave select disabled.
    do_cmd(11'h002);
    xfer(8'h96, 8'h69, 1'b0, 1'b0);

    // Randomized configurations and data.
    for (int it = 0; it < 8; it++) begin
      w  = {$urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            8'($urandom_range(0, 3))};
      tx = 8'($urandom);
      sb = 8'($urandom);
      do_cmd(w);
      xfer(tx, sb, 1'b0, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        access(K_RD, 11'h000, 1 + $urandom_range(0, 3), acks, rv);
        chk("rnd_rd_acks", acks, 1);
        chk("rnd_rd_rv", bus.din[8], 1'b0);
      end
    end

    // Reset in the middle of SHIFT (bit 4).
    do_cmd(11'h401);
    bus.dout = 11'h0F0;
    bus.wr   = 1'b1;
    @(posedge clk); #1;
    bus.wr = 1'b0;
    n      = 0;
    c      = 0;
    prev   = spi_sclk;
    while (n < 7 && c < 500) begin
      @(posedge clk); #1;
      c++;
      if (spi_sclk !== prev) n++;
      prev = spi_sclk;
    end
    chk("rst_reach_shift", n, 7);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_ss_n", spi_ss_n, 1'b1);
    chk("midrst_sclk", spi_sclk, 1'b0);
    chk("midrst_din", bus.din, 10'h000);
    chk("midrst_ack", bus.ack, 1'b0);
    rst = 1'b0;
    model_cmd(11'h403);
    @(posedge clk); #1;
    xfer(8'hC6, 8'h3B, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- Sequencer behind the Wishbone slave interface. It consumes the interface's internal strobes (cmd, wr, rd) and the 11-bit write word, and returns the 10-bit read word and ack.
- Holds the SPI configuration register and runs an 8-bit full-duplex SPI master transfer engine that supports modes 0–3.
- Drives the SPI pins directly: sclk, mosi, ss_n; samples miso.

Parameters:
- DIV_RESET, 8'd3, reset value of the SCK half-period divider.
- CPOL_RESET, 1'b0, reset value of clock polarity.
- CPHA_RESET, 1'b0, reset value of clock phase.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-high.
- dout  input  11  bus-to-slave word.
  - On cmd: [7:0]=div, [8]=cpol, [9]=cpha, [10]=ss_en.
  - On wr: [7:0]=tx byte; [10:8] ignored.
- cmd  input  1  configuration write request (level).
- wr  input  1  transmit-data write request (level).
- rd  input  1  receive-data read request (level).
- din  output  10  slave-to-bus word: [7:0]=rx_data, [8]=rx_valid, [9]=busy.
- ack  output  1  access acknowledge.
- spi_sclk  output  1  SPI clock.
- spi_mosi  output  1  SPI data out, MSB first.
- spi_miso  input  1  SPI data in, registered once before use.
- spi_ss_n  output  1  slave select, active-low.

Behaviour:
- Clock and reset are decided as: one clock; reset is synchronous and active-high (clk, rst).
- Reset values:
  - div=DIV_RESET, cpol=CPOL_RESET, cpha=CPHA_RESET, ss_en=1.
  - FSM=IDLE, busy=0, rx_valid=0, rx_data=0, ack=0.
  - spi_sclk=CPOL_RESET, spi_mosi=0, spi_ss_n=1.
- Request detection:
  - req = cmd|wr|rd, registered one cycle; an access is accepted on the req rising edge.
  - Priority when several strobes are high: cmd > wr > rd.
- Ack:
  - One-cycle pulse, asserted the cycle after acceptance.
  - No second ack until req has dropped and risen again.
  - Every accepted access is acked, even if its action is ignored.
- cmd accepted:
  - In IDLE: load div/cpol/cpha/ss_en from dout; spi_sclk updates to the new cpol the next cycle.
  - While busy: ignored (config locked), still acked.
- wr accepted:
  - In IDLE: load tx shift register = dout[7:0], busy=1, go to SETUP.
  - While busy: data dropped, still acked.
- rd accepted: din is valid combinationally at all times; rx_valid clears on the ack cycle unless a transfer completes in that same cycle, in which case completion wins and rx_valid stays 1.
- Timing unit: half-period H = div+1 clk cycles, from an 8-bit down-counter reloaded every H. div=0 gives H=1.
- SETUP (1 H):
  - ss_n=~ss_en.
  - If CPHA=0, MSB is driven on mosi at SETUP entry.
  - sclk stays at cpol.
- SHIFT (16 H): sclk toggles at each H boundary, 8 leading and 8 trailing edges.
  - CPHA=0: sample miso on leading edges; shift out the next bit on trailing edges, except after the 8th bit.
  - CPHA=1: drive the next bit on leading edges; sample on trailing edges.
- HOLD (1 H): sclk=cpol, ss_n held, then ss_n=1.
- Completion, at the end of HOLD:
  - rx_data <= shifted byte, rx_valid=1, busy=0, FSM=IDLE.
  - rx_valid from a previous transfer is overwritten.
- Total transfer time = 18·H clocks from the cycle after wr acceptance to busy falling.
- mosi holds its last bit in IDLE.
- Reset mid-transfer aborts immediately to reset values: ss_n=1 the next cycle, no rx_valid.

Test Plan:
- Config write: cmd with dout=11'h4_01 (ss_en=1, cpha=0, cpol=0, div=1) → one ack pulse.
  - Then wr 8'hA5 with miso looped to mosi → mosi sequence 1,0,1,0,0,1,0,1.
  - sclk half-period = 2 clk; busy high for 36 clk.
  - Final din = 10'h1A5.
- Mode 3 (dout=11'h7_00, div=0): wr 8'h3C, miso driven with 8'hC3 → sclk idles high; transfer 18 clk; din[7:0]=8'hC3; mosi changes on falling sclk edges.
- Busy collisions: wr 8'h11 then, mid-transfer, wr 8'h22 and cmd 11'h0FF → both acked; rx_data reflects 8'h11 traffic only; div unchanged (still 1); no second transfer.
- rd handshake: after a completed transfer, hold rd high 5 cycles → exactly one ack; rx_valid 1→0 on the ack cycle; din[9]=0.
- ss_en=0 (cmd 11'h0_02): transfer runs with spi_ss_n constantly 1 while sclk toggles 16 times.
- Reset at SHIFT bit 4 → next cycle ss_n=1, sclk=CPOL_RESET, busy=0, rx_valid=0, ack=0; a following wr runs normally with div=DIV_RESET (H=4).
